// File: rtl/ecc_70_err_collect.sv
// ecc_70_err_collect
//
// Read-side collector for the 70-bit ECC path. Corrected words and their
// error flags pass through a 2-entry skid buffer. Error events on accepted
// words feed saturating counters, sticky status bits, a first-uncorrectable
// address capture and a level interrupt.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_vld/in_rdy    upstream handshake; in_addr, in_data, in_sbit_err,
//                    in_dbit_err, in_ecc_fault travel with in_vld
//   out_vld/out_rdy  downstream handshake; out_data, out_err travel with out_vld
//   clr              synchronous clear of counters, sticky bits and capture
//   irq_en           interrupt enables {fault, dbit, sbit}
//   sbit_cnt, dbit_cnt, fault_cnt   saturating event counters
//   err_sticky       sticky {fault, dbit, sbit}
//   first_err_addr/first_err_vld    first dbit-or-fault address since clear
//   irq              registered interrupt level
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source holds valid and its payload stable until that edge;
// ready never depends combinationally on valid in the same cycle.

module ecc_70_err_collect #(
    parameter int DATA_WIDTH = 70,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic                  in_ecc_fault,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_err,
    input  logic                  clr,
    input  logic [2:0]            irq_en,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [2:0]            err_sticky,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  first_err_vld,
    output logic                  irq
);

    // Buffer entry layout: {dbit|fault, sbit, data}
    localparam int EW = DATA_WIDTH + 2;

    logic [EW-1:0] ent0, ent1;
    logic          wr_ptr, rd_ptr;
    logic [1:0]    occ, occ_nxt;
    logic          in_rdy_q;
    logic          push, pop;
    logic [EW-1:0] in_word, head;

    assign push    = in_vld & in_rdy_q;
    assign pop     = (occ != 2'd0) & out_rdy;
    assign in_word = {in_dbit_err | in_ecc_fault, in_sbit_err, in_data};
    assign head    = rd_ptr ? ent1 : ent0;

    assign in_rdy   = in_rdy_q;
    assign out_vld  = (occ != 2'd0);
    assign out_data = head[DATA_WIDTH-1:0];
    assign out_err  = head[EW-1 -: 2];

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    // in_rdy is taken from the next occupancy, so out_rdy only reaches
    // in_rdy through this register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0     <= '0;
            ent1     <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            in_rdy_q <= 1'b1;
        end else begin
            if (push) begin
                if (wr_ptr) ent1 <= in_word;
                else        ent0 <= in_word;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ      <= occ_nxt;
            in_rdy_q <= (occ_nxt != 2'd2);
        end
    end

    // Events only exist on accepted words; flags are ignored otherwise.
    logic       ev_s, ev_d, ev_f, ev_u;
    logic [2:0] ev_vec;

    assign ev_s   = push & in_sbit_err;
    assign ev_d   = push & in_dbit_err;
    assign ev_f   = push & in_ecc_fault;
    assign ev_u   = ev_d | ev_f;
    assign ev_vec = {ev_f, ev_d, ev_s};

    // A clear in the same cycle as an event leaves that event counted once.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 ev,
        input logic                 clear
    );
        logic [CNT_WIDTH-1:0] res;
        res = cnt;
        if (clear)
            res = ev ? CNT_WIDTH'(1) : '0;
        else if (ev && (cnt != '1))
            res = cnt + CNT_WIDTH'(1);
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbit_cnt       <= '0;
            dbit_cnt       <= '0;
            fault_cnt      <= '0;
            err_sticky     <= 3'b000;
            first_err_addr <= '0;
            first_err_vld  <= 1'b0;
            irq            <= 1'b0;
        end else begin
            sbit_cnt  <= cnt_next(sbit_cnt,  ev_s, clr);
            dbit_cnt  <= cnt_next(dbit_cnt,  ev_d, clr);
            fault_cnt <= cnt_next(fault_cnt, ev_f, clr);

            err_sticky <= clr ? ev_vec : (err_sticky | ev_vec);

            if (clr) begin
                first_err_vld  <= ev_u;
                first_err_addr <= ev_u ? in_addr : '0;
            end else if (!first_err_vld && ev_u) begin
                first_err_vld  <= 1'b1;
                first_err_addr <= in_addr;
            end

            // Built from the sticky register, so irq trails the event by a cycle.
            irq <= |(err_sticky & irq_en);
        end
    end

endmodule

// File: doc/ecc_70_err_collect.md
Name: ecc_70_err_collect

Overview:
- Downstream stage of the 70-bit ECC fault-detect/correct path, sitting on the memory/FIFO read side.
- Registers the corrected data and its error flags through a 2-entry valid/ready skid buffer.
- Counts single-bit, double-bit and ECC-logic-fault events; holds sticky status and the address of the first uncorrectable event; raises an interrupt.

Parameters:
- DATA_WIDTH, 70, corrected data width.
- ADDR_WIDTH, 8, read address width carried alongside the data.
- CNT_WIDTH, 16, width of each saturating error counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  upstream read data valid.
- in_rdy  output  1  block can accept a word.
- in_addr  input  ADDR_WIDTH  address of the word being read.
- in_data  input  DATA_WIDTH  corrected data from the fault-detect stage.
- in_sbit_err  input  1  single-bit error (corrected).
- in_dbit_err  input  1  double-bit error (uncorrectable).
- in_ecc_fault  input  1  duplicated-decoder mismatch.
- out_vld  output  1  output word valid.
- out_rdy  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  registered data.
- out_err  output  2  {dbit|fault, sbit} registered with data.
- clr  input  1  synchronous pulse: clear counters, sticky bits and capture.
- irq_en  input  3  enables {fault, dbit, sbit}.
- sbit_cnt  output  CNT_WIDTH  saturating single-bit count.
- dbit_cnt  output  CNT_WIDTH  saturating double-bit count.
- fault_cnt  output  CNT_WIDTH  saturating ECC-fault count.
- err_sticky  output  3  {fault, dbit, sbit} sticky.
- first_err_addr  output  ADDR_WIDTH  address of the first dbit or fault event since clear.
- first_err_vld  output  1  first_err_addr holds a capture.
- irq  output  1  interrupt, level.

Behaviour:
- Reset: all outputs 0 except in_rdy = 1; buffer empty.
- Accept: word accepted when in_vld & in_rdy. Data and flags are captured together.
- Buffer: 2 entries, FIFO order. Tracked by occupancy count 0..2.
  - out_vld = (occ != 0); out_data/out_err come from the head entry.
  - Pop when out_vld & out_rdy.
  - in_rdy is registered: 1 when next occ < 2, so there is no combinational path from out_rdy to in_rdy.
  - Push and pop in the same cycle leaves occ unchanged; order is preserved.
  - Push is blocked at occ == 2. A push at occ == 2 with in_rdy = 0 is not an accept and must not be counted.
  - Latency: a word accepted in cycle N with empty buffer gives out_vld = 1 in cycle N+1.
- out_err[1] = dbit | fault, out_err[0] = sbit.
- If in_ecc_fault = 1, sbit/dbit of that word still count independently.
- Counters increment only on accept. Each is +1 per event and saturates at all-ones with no wrap.
- clr:
  - Counter next value = event_this_cycle ? 1 : 0.
  - Sticky next value = event_this_cycle.
  - first_err_vld next value = (dbit | fault) this cycle; if set, first_err_addr loads in_addr.
  - clr never affects the data buffer.
- Sticky bits set on accepted events and hold until clr.
- Capture: first_err_addr loads only when first_err_vld = 0 and an accepted word has dbit or fault. Later events do not overwrite it.
- irq = |(err_sticky & irq_en), registered (err_sticky is itself a register, so irq follows one cycle after the event).
- Reset asserted mid-transfer: buffer flushed; in-flight words discarded without counting.
- X on in_* while in_vld = 0 has no effect.

Test Plan:
- Stream 4 clean words, addr 0..3, with out_rdy = 1 → each appears 1 cycle later, out_err = 0, all counters 0, in_rdy stays 1.
- out_rdy = 0, push 3 words → occ reaches 2, in_rdy drops the cycle after the 2nd accept, the 3rd word is held upstream. Raise out_rdy → words exit in order, in_rdy returns to 1.
- Accept sbit at addr 0x10, then dbit at 0x20, then fault at 0x30 → sbit_cnt = 1, dbit_cnt = 1, fault_cnt = 1, err_sticky = 3'b111, first_err_addr = 0x20, first_err_vld = 1.
- Apply clr in the same cycle as an accepted dbit at addr 0x44 → dbit_cnt = 1, sticky = 3'b010, first_err_addr = 0x44, other counters 0.
- CNT_WIDTH = 4, 20 accepted sbit words → sbit_cnt sticks at 15. irq_en = 3'b001 gives irq = 1; irq_en = 0 gives irq = 0.
- Assert rst_n = 0 with occ = 2 and 5 counted errors → all outputs 0, in_rdy = 1 after release, the 2 buffered words never appear.
